// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : constants and types shared by the fetch queue and the core
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam logic [31:0] C_NOP          = 32'h0000_0013;
  localparam logic [31:0] C_RESET_PC     = 32'h4000_0000;
  localparam logic [3:0]  C_REGION_BIOS  = 4'h4;
  localparam logic [3:0]  C_REGION_IMEM  = 4'h1;

  localparam logic [6:0]  C_OPC_LUI      = 7'b0110111;
  localparam logic [6:0]  C_OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0]  C_OPC_JAL      = 7'b1101111;
  localparam logic [6:0]  C_OPC_JALR     = 7'b1100111;
  localparam logic [6:0]  C_OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  C_OPC_LOAD     = 7'b0000011;
  localparam logic [6:0]  C_OPC_STORE    = 7'b0100011;
  localparam logic [6:0]  C_OPC_ARI_I    = 7'b0010011;
  localparam logic [6:0]  C_OPC_ARI_R    = 7'b0110011;
  localparam logic [6:0]  C_OPC_CSR      = 7'b1110011;

  // One FIFO slot: fetch address in the upper half, instruction word below.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic region_is(input logic [31:0] pc, input logic [3:0] region);
    return pc[31:28] == region;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : power-of-two FIFO with wrap-bit pointers and synchronous flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_pop;
  logic               w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign head  = r_mem[r_rd_ptr[c_aw-1:0]];

  // A push into a full FIFO is only accepted when the head leaves that cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : decoupled instruction fetch with DEPTH-entry prefetch FIFO
// Optional same-cycle response bypass when FETCH_BYPASS_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = C_RESET_PC,
  parameter logic [3:0]  BIOS_REGION = C_REGION_BIOS,
  parameter int          BIOS_AW     = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_re,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_data,
  output logic               bios_re,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_data,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  input  logic               inst_ready
);

  localparam int               c_aw    = $clog2(DEPTH);
  localparam logic [c_aw+1:0]  c_depth = (c_aw+2)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic          r_epoch;
  logic          r_pending;
  logic          r_resp_sel_bios;
  logic [31:0]   r_resp_pc;
  logic          r_resp_epoch;

  logic [31:0]   w_req_pc;
  logic          w_sel_bios;
  logic [c_aw+1:0] w_occ;
  logic          w_issue;
  logic [31:0]   w_resp_data;
  logic          w_resp_ok;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_head_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_fifo_head;
  fetch_entry_t  w_resp_entry;
  logic [c_aw:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_unused_bits;

  assign w_req_pc   = redirect_valid ? {redirect_pc[31:2], 2'b00} : r_fetch_pc;
  assign w_sel_bios = region_is(w_req_pc, BIOS_REGION);

  // A redirect flushes the queue, so only the in-flight response counts then.
  assign w_occ   = redirect_valid ? {{(c_aw+1){1'b0}}, r_pending}
                                  : {1'b0, w_count} + {{(c_aw+1){1'b0}}, r_pending};
  assign w_issue = rst_n && !stall && (w_occ < c_depth);

  assign imem_re   = w_issue && !w_sel_bios;
  assign bios_re   = w_issue &&  w_sel_bios;
  assign imem_addr = {4'b0000, w_req_pc[27:2], 2'b00};
  assign bios_addr = w_req_pc[BIOS_AW+1:2];

  assign w_resp_data  = r_resp_sel_bios ? bios_data : imem_data;
  assign w_resp_ok    = !stall && r_pending && (r_resp_epoch == r_epoch) && !redirect_valid;
  assign w_resp_entry = '{pc: r_resp_pc, inst: w_resp_data};
  assign w_flush      = !stall && redirect_valid;
  assign w_pop        = !stall && !redirect_valid && inst_ready && !w_empty;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  // An empty queue lets the arriving response be seen (and taken) directly.
  assign w_bypass     = w_empty && w_resp_ok;
  assign w_push       = w_resp_ok && !(w_bypass && inst_ready);
  assign w_head_valid = !w_empty || w_bypass;
  assign w_head       = w_empty ? w_resp_entry : w_fifo_head;
`else
  assign w_push       = w_resp_ok;
  assign w_head_valid = !w_empty;
  assign w_head       = w_fifo_head;
`endif

  assign inst_valid = w_head_valid;
  assign inst       = w_head_valid ? w_head.inst : C_NOP;
  assign inst_pc    = w_head_valid ? w_head.pc   : 32'h0;

  assign w_unused_bits = ^{redirect_pc[1:0], w_req_pc[1:0], w_full};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_resp_entry),
    .head  (w_fifo_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc      <= RESET_PC;
      r_epoch         <= 1'b0;
      r_pending       <= 1'b0;
      r_resp_sel_bios <= 1'b0;
      r_resp_pc       <= 32'h0;
      r_resp_epoch    <= 1'b0;
    end else if (!stall) begin
      if (redirect_valid) r_epoch <= ~r_epoch;
      r_pending <= w_issue;
      if (w_issue) begin
        r_fetch_pc      <= w_req_pc + 32'd4;
        r_resp_sel_bios <= w_sel_bios;
        r_resp_pc       <= w_req_pc;
        // Tag with the epoch that will be current when the data returns.
        r_resp_epoch    <= redirect_valid ? ~r_epoch : r_epoch;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage: decoupled instruction fetch unit with a DEPTH-entry prefetch FIFO.
- Sits between the BIOS/icache instruction ports and the execute stage.
- Issues one sequential fetch per cycle while credit is available; handles branch/jump redirect with an epoch bit that discards stale in-flight responses.
- Presents instructions to execute through a valid/ready handshake.

Parameters:
- DEPTH, 4: prefetch FIFO entries; power of 2, ≥2.
- RESET_PC, 32'h40000000: fetch PC after reset.
- BIOS_REGION, 4'h4: pc[31:28] value that selects the BIOS port.
- BIOS_AW, 12: BIOS word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- stall  in  1  global freeze, same meaning as the CPU-wide stall.
- redirect_valid  in  1  take redirect_pc this cycle.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored.
- imem_re  out  1  icache read enable.
- imem_addr  out  32  {4'b0, pc[27:2], 2'b00}.
- imem_data  in  32  icache data; valid the cycle after imem_re.
- bios_re  out  1  BIOS read enable.
- bios_addr  out  BIOS_AW  pc[BIOS_AW+1:2].
- bios_data  in  32  BIOS data; valid the cycle after bios_re.
- inst_valid  out  1  FIFO head valid.
- inst  out  32  head instruction; NOP (32'h13) when !inst_valid.
- inst_pc  out  32  PC of head instruction.
- inst_ready  in  1  execute accepts the head this cycle.

Behaviour:
- **Reset (rst_n=0, async):**
  - fetch_pc=RESET_PC, FIFO empty, pending=0, epoch=0.
  - inst_valid=0, inst=32'h13, inst_pc=0, imem_re=bios_re=0.
- **Request address:** req_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc.
- **Region select:** sel_bios = (req_pc[31:28]==BIOS_REGION). Exactly one of bios_re/imem_re is asserted when issuing.
- **Issue condition:** !stall && (count + pending + (redirect_valid ? -count : 0)) < DEPTH. On issue, fetch_pc <= req_pc+4; 32-bit wrap, 32'hFFFFFFFC -> 0.
- **Response:**
  - pending, resp_sel_bios, resp_pc and resp_epoch are registered at issue.
  - The next non-stalled cycle, data is taken from the port selected by resp_sel_bios.
  - It is pushed only if resp_epoch==epoch and no redirect is asserted that cycle.
- **Latency:**
  - Redirect at cycle T -> request at T -> data at T+1 -> inst_valid at T+2.
  - Sequential steady state sustains 1 instruction/cycle when inst_ready is held high.
- **Redirect (not stalled):**
  - Flushes the FIFO (count=0) and toggles epoch.
  - A response returning in the same or next cycle with the old epoch is dropped.
  - A concurrent inst_ready pop is ignored.
  - The redirect request itself is issued that cycle regardless of the old occupancy.
- **Push/pop:**
  - Simultaneous push and pop with count=DEPTH is legal; count is unchanged.
  - Pop on empty is ignored.
  - Pointers are log2(DEPTH)+1 bits with wrap bit; full = MSBs differ and low bits equal.
- **Stall:**
  - All state is held; imem_re=bios_re=0, so the memories hold their douts.
  - A pending response is captured on the first cycle after stall deasserts.
  - redirect_valid and inst_ready are ignored; sources must hold them.
- **Outputs:** inst_valid/inst/inst_pc are driven combinationally from the FIFO head. No combinational path from inst_ready to the outputs.

Optional Feature:
- FETCH_BYPASS_EN
  - Defined: when the FIFO is empty and a valid response arrives, it drives inst/inst_pc/inst_valid the same cycle. If inst_ready is high it is consumed without a push; otherwise it is pushed. Redirect-to-valid latency drops to T+1.
  - Undefined: all responses pass through the FIFO; T+2 latency as above.

Decomposition:
- Shared constants header/package:
  - NOP encoding 32'h13.
  - RESET_PC default 32'h40000000.
  - Region nibbles (BIOS 4'h4, IMEM 4'h1).
  - Opcode defines already shared with the core.
- Sub-module fetch_fifo (DEPTH, WIDTH=64 for {pc,inst}):
  - Synchronous push/pop/flush, async active-low reset.
  - Outputs count, full, empty, head.

Test Plan:
- Reset, rst_n released, inst_ready=1, BIOS returns addr-tagged data -> first inst_valid at cycle 2 with inst_pc=32'h40000000, then 32'h40000004, 32'h40000008 on consecutive cycles.
- inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered, no further bios_re, count never exceeds 4; releasing inst_ready drains 40000000..4000000C then resumes at 40000010.
- Redirect to 32'h10000102 while 3 entries and 1 pending exist -> FIFO flushed, stale response dropped, imem_re with imem_addr=32'h00000100, next inst_pc=32'h10000100.
- stall held 5 cycles with a response pending -> no re asserted, outputs frozen; after release, pending data appears with the correct pc, no duplicate and no loss.
- Sequential fetch from 32'h4FFFFFFC to 32'h50000000 -> bios_re for the first address, imem_re for the second; the response mux follows the registered select.
- With FETCH_BYPASS_EN defined, redirect at T with empty FIFO -> inst_valid at T+1; undefined -> T+2.
